// File: rtl/matmul_sequencer.sv
// Control FSM that steps one multiply-accumulate unit through an N x N signed matrix product.
// It issues row-major A/B read addresses and the MAC enable/clear, and writes each C element over valid/ready.
module matmul_sequencer #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N),
  localparam int AW = 2 * $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          mac_enable,
  output logic          mac_clear,
  output logic          c_valid,
  input  logic          c_ready,
  output logic [AW-1:0] c_addr
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WRITE, DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state, state_n;
  logic [IW-1:0] i, j, k;
  logic [IW-1:0] i_n, j_n, k_n, kk_n;

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CLEAR;
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
        end
      end
      CLEAR: begin
        state_n = FEED;
        k_n     = '0;
      end
      FEED: begin
        if (k == LAST) state_n = WRITE;
        else           k_n     = k + 1'b1;
      end
      WRITE: begin
        if (c_ready) begin
          k_n = '0;
          if (j == LAST) begin
            j_n     = '0;
            i_n     = i + 1'b1;
            state_n = (i == LAST) ? DONE : CLEAR;
          end else begin
            j_n     = j + 1'b1;
            state_n = CLEAR;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // During FEED the memories are one operand ahead; the last operand's address is held.
    kk_n = (state_n == FEED && k_n != LAST) ? k_n + 1'b1 : k_n;
  end

  // Outputs are registered from the next-state values, so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mac_enable <= 1'b0;
      mac_clear  <= 1'b0;
      c_valid    <= 1'b0;
      a_addr     <= '0;
      b_addr     <= '0;
      c_addr     <= '0;
    end else begin
      state      <= state_n;
      i          <= i_n;
      j          <= j_n;
      k          <= k_n;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      mac_clear  <= (state_n == CLEAR);
      mac_enable <= (state_n == FEED);
      c_valid    <= (state_n == WRITE);
      if (state_n == CLEAR || state_n == FEED || state_n == WRITE) begin
        a_addr <= {i_n, kk_n};
        b_addr <= {kk_n, j_n};
      end else begin
        a_addr <= '0;
        b_addr <= '0;
      end
      c_addr <= (state_n == WRITE) ? {i_n, j_n} : '0;
    end
  end

endmodule
